// File: rtl/channel_select_fsm.sv
// rtl/channel_select_fsm.sv - debounced switch to frame-buffer channel selector
// Switches are synchronised and debounced; the capture channel only changes on frame_start.
module channel_select_fsm #(
  parameter int NUM_CH          = 3,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 16
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic [NUM_CH-1:0]                            sw,
  input  logic                                         sw_clr,
  input  logic                                         frame_start,
  input  logic                                         pix_valid,
  output logic [NUM_CH-1:0]                            w_en,
  output logic [(NUM_CH > 1 ? $clog2(NUM_CH) : 1)-1:0] sel,
  output logic                                         active,
  output logic [CNT_W-1:0]                             frame_count,
  output logic [9:0]                                   ledr
);

  localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ARMED  = 2'd1;
  localparam logic [1:0] ST_ACTIVE = 2'd2;

  logic [NUM_CH-1:0] r_sync1;
  logic [NUM_CH-1:0] r_sync2;
  logic [NUM_CH-1:0] r_sw_db;
  logic [DB_W-1:0]   r_db_cnt [NUM_CH];

  logic [1:0]        r_state;
  logic [SEL_W-1:0]  r_pend_ch;
  logic [SEL_W-1:0]  r_cur_ch;
  logic [CNT_W-1:0]  r_frame_count;

  logic [SEL_W-1:0]  w_req_idx;
  logic              w_req_any;

  // The counter runs while the synchronised bit disagrees with the debounced bit;
  // any return to agreement restarts it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_sw_db <= '0;
      for (int i = 0; i < NUM_CH; i++) r_db_cnt[i] <= '0;
    end else begin
      r_sync1 <= sw;
      r_sync2 <= r_sync1;
      for (int i = 0; i < NUM_CH; i++) begin
        if (r_sync2[i] == r_sw_db[i]) begin
          r_db_cnt[i] <= '0;
        end else if (r_db_cnt[i] == DB_LAST) begin
          r_sw_db[i]  <= r_sync2[i];
          r_db_cnt[i] <= '0;
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + DB_W'(1);
        end
      end
    end
  end

  always_comb begin
    w_req_idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (r_sw_db[i]) w_req_idx = SEL_W'(i);
    end
  end

  assign w_req_any = |r_sw_db;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_pend_ch     <= '0;
      r_cur_ch      <= '0;
      r_frame_count <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_req_any) begin
            r_pend_ch <= w_req_idx;
            r_state   <= ST_ARMED;
          end
        end
        ST_ARMED: begin
          if (sw_clr) begin
            r_state <= ST_IDLE;
          end else if (frame_start) begin
            r_cur_ch      <= r_pend_ch;
            r_frame_count <= r_frame_count + CNT_W'(1);
            r_state       <= ST_ACTIVE;
          end else if (w_req_any) begin
            r_pend_ch <= w_req_idx;
          end
        end
        ST_ACTIVE: begin
          if (sw_clr) begin
            r_state <= ST_IDLE;
          end else if (frame_start) begin
            r_frame_count <= r_frame_count + CNT_W'(1);
            if (w_req_any) r_cur_ch <= w_req_idx;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // sw_clr gates the write enable in the same cycle it is seen.
  assign w_en = (r_state == ST_ACTIVE && pix_valid && !sw_clr) ?
                (NUM_CH'(1) << r_cur_ch) : '0;

  assign sel         = r_cur_ch;
  assign active      = (r_state == ST_ACTIVE);
  assign frame_count = r_frame_count;

  always_comb begin
    ledr    = '0;
    ledr[0] = (r_state == ST_IDLE);
    ledr[1] = (r_state == ST_ARMED);
    ledr[2] = (r_state == ST_ACTIVE);
    for (int i = 0; i < NUM_CH; i++) begin
      ledr[3+i] = (r_state == ST_ACTIVE) && (r_cur_ch == SEL_W'(i));
    end
  end

endmodule

// File: tb/tb_channel_select_fsm.sv
// tb/tb_channel_select_fsm.sv - directed scoreboard bench for channel_select_fsm
// Two builds share control inputs: 3 channels/debounce 16/8-bit count and 7 channels/debounce 2.
module tb_channel_select_fsm;

  logic       clk = 1'b0;
  logic       rst;
  logic       sw_clr;
  logic       frame_start;
  logic       pix_valid;

  logic [2:0] sw_a;
  logic [2:0] w_en_a;
  logic [1:0] sel_a;
  logic       active_a;
  logic [7:0] fc_a;
  logic [9:0] ledr_a;

  logic [6:0] sw_b;
  logic [6:0] w_en_b;
  logic [2:0] sel_b;
  logic       active_b;
  logic [3:0] fc_b;
  logic [9:0] ledr_b;

  typedef struct {
    string      tag;
    int         dut;
    logic [6:0] w_en;
    logic [2:0] sel;
    logic       active;
    logic [7:0] fc;
    logic [9:0] ledr;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  channel_select_fsm #(.NUM_CH(3), .DEBOUNCE_CYCLES(16), .CNT_W(8)) u_dut_a (
    .clk(clk), .rst(rst), .sw(sw_a), .sw_clr(sw_clr), .frame_start(frame_start),
    .pix_valid(pix_valid), .w_en(w_en_a), .sel(sel_a), .active(active_a),
    .frame_count(fc_a), .ledr(ledr_a)
  );

  channel_select_fsm #(.NUM_CH(7), .DEBOUNCE_CYCLES(2), .CNT_W(4)) u_dut_b (
    .clk(clk), .rst(rst), .sw(sw_b), .sw_clr(sw_clr), .frame_start(frame_start),
    .pix_valid(pix_valid), .w_en(w_en_b), .sel(sel_b), .active(active_b),
    .frame_count(fc_b), .ledr(ledr_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input string tag, input int dut, input logic [6:0] w,
                          input logic [2:0] s, input logic a, input logic [7:0] f,
                          input logic [9:0] l);
    exp_t e;
    e.tag = tag; e.dut = dut; e.w_en = w; e.sel = s; e.active = a; e.fc = f; e.ledr = l;
    sb.push_back(e);
  endtask

  task automatic observe();
    exp_t       e;
    logic [6:0] ow;
    logic [2:0] os;
    logic       oa;
    logic [7:0] of;
    logic [9:0] ol;
    @(negedge clk);
    if (sb.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
      return;
    end
    e = sb.pop_front();
    if (e.dut == 0) begin
      ow = {4'b0, w_en_a}; os = {1'b0, sel_a}; oa = active_a; of = fc_a; ol = ledr_a;
    end else begin
      ow = w_en_b; os = sel_b; oa = active_b; of = {4'b0, fc_b}; ol = ledr_b;
    end
    n_tests++;
    assert (ow === e.w_en) else begin
      n_fail++; $error("FAIL %s.w_en observed=%b expected=%b", e.tag, ow, e.w_en);
    end
    n_tests++;
    assert (os === e.sel) else begin
      n_fail++; $error("FAIL %s.sel observed=%0d expected=%0d", e.tag, os, e.sel);
    end
    n_tests++;
    assert (oa === e.active) else begin
      n_fail++; $error("FAIL %s.active observed=%b expected=%b", e.tag, oa, e.active);
    end
    n_tests++;
    assert (of === e.fc) else begin
      n_fail++; $error("FAIL %s.frame_count observed=%0d expected=%0d", e.tag, of, e.fc);
    end
    n_tests++;
    assert (ol === e.ledr) else begin
      n_fail++; $error("FAIL %s.ledr observed=%b expected=%b", e.tag, ol, e.ledr);
    end
  endtask

  task automatic chk_a(input string tag, input logic [2:0] w, input logic [1:0] s,
                       input logic a, input logic [7:0] f, input logic [9:0] l);
    push_exp(tag, 0, {4'b0, w}, {1'b0, s}, a, f, l);
    observe();
  endtask

  task automatic chk_b(input string tag, input logic [6:0] w, input logic [2:0] s,
                       input logic a, input logic [3:0] f, input logic [9:0] l);
    push_exp(tag, 1, w, s, a, {4'b0, f}, l);
    observe();
  endtask

  initial begin
    rst = 1'b1; sw_a = '0; sw_b = '0; sw_clr = 1'b0; frame_start = 1'b0; pix_valid = 1'b0;
    tick(); tick();
    chk_a("reset", 3'b000, 2'd0, 1'b0, 8'd0, 10'd1);
    tick();
    rst = 1'b0;

    // Pulses shorter than the debounce window must never arm the FSM.
    sw_a = 3'b010; repeat (10) tick(); sw_a = 3'b000; repeat (25) tick();
    chk_a("glitch_10", 3'b000, 2'd0, 1'b0, 8'd0, 10'd1);
    tick();
    sw_a = 3'b010; repeat (15) tick(); sw_a = 3'b000; repeat (25) tick();
    chk_a("glitch_15", 3'b000, 2'd0, 1'b0, 8'd0, 10'd1);
    tick();

    sw_a = 3'b010; repeat (18) tick();
    chk_a("arm_edge18", 3'b000, 2'd0, 1'b0, 8'd0, 10'd1);
    tick();
    chk_a("arm_edge19", 3'b000, 2'd0, 1'b0, 8'd0, 10'd2);
    tick();

    frame_start = 1'b1; pix_valid = 1'b1;
    chk_a("entry_fs_pixel", 3'b000, 2'd0, 1'b0, 8'd0, 10'd2);
    tick();
    frame_start = 1'b0;
    chk_a("active_ch1", 3'b010, 2'd1, 1'b1, 8'd1, 10'd20);
    tick();
    pix_valid = 1'b0;
    chk_a("active_novalid", 3'b000, 2'd1, 1'b1, 8'd1, 10'd20);
    tick();
    pix_valid = 1'b1;

    sw_a = 3'b101; repeat (20) tick();
    chk_a("hold_ch1", 3'b010, 2'd1, 1'b1, 8'd1, 10'd20);
    tick();
    frame_start = 1'b1;
    chk_a("fs_old_ch1", 3'b010, 2'd1, 1'b1, 8'd1, 10'd20);
    tick();
    frame_start = 1'b0;
    chk_a("prio_ch0", 3'b001, 2'd0, 1'b1, 8'd2, 10'd12);
    tick();

    sw_a = 3'b100; repeat (20) tick();
    chk_a("hold_ch0", 3'b001, 2'd0, 1'b1, 8'd2, 10'd12);
    tick();
    frame_start = 1'b1;
    chk_a("fs_old_ch0", 3'b001, 2'd0, 1'b1, 8'd2, 10'd12);
    tick();
    frame_start = 1'b0;
    chk_a("switch_ch2", 3'b100, 2'd2, 1'b1, 8'd3, 10'd36);
    tick();

    sw_clr = 1'b1; frame_start = 1'b1;
    chk_a("clr_gate", 3'b000, 2'd2, 1'b1, 8'd3, 10'd36);
    tick();
    sw_clr = 1'b0; frame_start = 1'b0;
    chk_a("clr_idle", 3'b000, 2'd2, 1'b0, 8'd3, 10'd1);
    tick();
    chk_a("rearm", 3'b000, 2'd2, 1'b0, 8'd3, 10'd2);
    tick();
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    chk_a("reentry_ch2", 3'b100, 2'd2, 1'b1, 8'd4, 10'd36);
    tick();

    sw_a = 3'b000; repeat (22) tick();
    chk_a("release_keeps", 3'b100, 2'd2, 1'b1, 8'd4, 10'd36);
    tick();
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    chk_a("release_fs", 3'b100, 2'd2, 1'b1, 8'd5, 10'd36);
    tick();

    rst = 1'b1; tick();
    chk_a("rst_midframe", 3'b000, 2'd0, 1'b0, 8'd0, 10'd1);
    tick();
    rst = 1'b0;

    sw_a = 3'b001; repeat (5) tick();
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    chk_a("no_early_restart", 3'b000, 2'd0, 1'b0, 8'd0, 10'd1);
    tick();
    repeat (15) tick();
    chk_a("rearm_after_rst", 3'b000, 2'd0, 1'b0, 8'd0, 10'd2);
    tick();
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    chk_a("ch0_after_rst", 3'b001, 2'd0, 1'b1, 8'd1, 10'd12);
    tick();

    for (int k = 0; k < 254; k++) begin
      frame_start = 1'b1; tick(); frame_start = 1'b0; tick();
    end
    chk_a("fc_255", 3'b001, 2'd0, 1'b1, 8'd255, 10'd12);
    tick();
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    chk_a("fc_wrap", 3'b001, 2'd0, 1'b1, 8'd0, 10'd12);
    tick();

    chk_b("b_idle_ignores_fs", 7'b0, 3'd0, 1'b0, 4'd0, 10'd1);
    tick();
    sw_b = 7'b1000000; repeat (4) tick();
    chk_b("b_arm_edge4", 7'b0, 3'd0, 1'b0, 4'd0, 10'd1);
    tick();
    chk_b("b_arm_edge5", 7'b0, 3'd0, 1'b0, 4'd0, 10'd2);
    tick();
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    chk_b("b_ch6", 7'b1000000, 3'd6, 1'b1, 4'd1, 10'b1000000100);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/channel_select_fsm.md
# channel_select_fsm

Parametrised colour-channel capture controller for the Sobel pipeline. Debounces the board switches and selects one of `NUM_CH` frame-buffer channels by fixed priority. It raises exactly one write enable per accepted pixel and changes the active channel only on a frame boundary, so a frame is never split across buffers. It sits between the switch/LED board I/O and the per-channel frame-buffer write ports, and replaces the fixed three-channel selector.

## Interface
Parameters:
- `NUM_CH`, default 3: number of channels and switches. Legal range 1..7.
- `DEBOUNCE_CYCLES`, default 16: number of consecutive stable synchronised samples needed before a debounced switch bit changes. Must be ≥ 1.
- `CNT_W`, default 16: width of the frame counter.

Ports (clock and reset first):
- `clk`, input, 1: single clock for all logic.
- `rst`, input, 1: reset, synchronous and active-high. Clears every register.
- `sw`, input, `NUM_CH`: raw asynchronous switches. Bit i requests channel i.
- `sw_clr`, input, 1: synchronous request to return to IDLE; any level counts.
- `frame_start`, input, 1: one-cycle pulse marking the first pixel cycle of a frame.
- `pix_valid`, input, 1: the pixel on the bus this cycle is valid.
- `w_en`, output, `NUM_CH`: one-hot or zero write enable per channel.
- `sel`, output, `$clog2(NUM_CH)` (minimum 1): current channel index.
- `active`, output, 1: high when the state is ACTIVE.
- `frame_count`, output, `CNT_W`: frames started while capturing.
- `ledr`, output, 10: status LEDs.

## Operation
- Switch input path:
  - Each `sw` bit passes through a 2-flop synchroniser, then a per-bit stability counter.
  - Debounced bit `sw_db[i]` takes the synchronised value once it has been stable for `DEBOUNCE_CYCLES` cycles. Any change in the synchronised value restarts the counter.
- Priority: `req_idx` is the lowest index with `sw_db` set; `req_any` is the OR of all `sw_db` bits.
- State IDLE (reset state):
  - If `req_any`: latch `pend_ch = req_idx` and go to ARMED.
  - `frame_start` in IDLE is ignored. Capture never begins mid-frame.
- State ARMED:
  - On `frame_start`: set `cur_ch = pend_ch`, increment `frame_count`, go to ACTIVE.
  - While waiting, `pend_ch` tracks `req_idx` whenever `req_any` is high.
  - If `req_any` drops, stay in ARMED with the last `pend_ch`.
- State ACTIVE:
  - `w_en[cur_ch] = pix_valid`; all other bits are 0.
  - On `frame_start`: increment `frame_count` (wraps modulo 2^`CNT_W`). If `req_any` is high and `req_idx != cur_ch`, set `cur_ch = req_idx`.
  - Releasing all switches does not stop capture. The channel stays latched until `sw_clr` or `rst`.
- `sw_clr` in ARMED or ACTIVE:
  - Next state is IDLE.
  - `w_en` is forced to 0 in the same cycle (combinational gate).
  - `cur_ch` and `frame_count` are held.
- `sel = cur_ch`; `active = (state == ACTIVE)`.
- `ledr` mapping:
  - `ledr[0]` = IDLE, `ledr[1]` = ARMED, `ledr[2]` = ACTIVE.
  - `ledr[3+i]` = (ACTIVE and `cur_ch == i`).
  - Unused upper bits are 0.

## Timing
- Reset values: state IDLE, `w_en` = 0, `sel` = 0, `active` = 0, `frame_count` = 0, `ledr` = 10'b0000000001. Synchroniser flops, stability counters and `sw_db` are all 0.
- Debounce latency: a raw `sw` edge held stable appears in `sw_db` exactly `DEBOUNCE_CYCLES + 2` clock edges later. A glitch shorter than `DEBOUNCE_CYCLES` cycles after synchronisation is never seen.
- IDLE→ARMED occurs 1 edge after `req_any` rises.
- Frame entry: `frame_start` in ARMED at cycle t → `active` = 1 at t+1. `w_en` follows `pix_valid` from t+1. The `frame_start` pixel itself is not written.
- Channel switch in ACTIVE: with `frame_start` at t, the new channel is `w_en`-visible from t+1. Pixels up to and including t go to the old channel.
- Simultaneous events:
  - `rst` beats everything.
  - `sw_clr` beats `frame_start`: no count increment, no channel change.
  - `frame_start` together with a `req_idx` change uses the value registered in that cycle.
- Reset mid-frame: `w_en` is 0 on the edge after `rst` rises, and capture restarts only after a fresh debounce and ARMED cycle.

## Test plan
- Reset, then `sw` = 3'b010 held 30 cycles with `DEBOUNCE_CYCLES` = 16 → ARMED 19 edges after the `sw` change. `frame_start` → `active` = 1, `sel` = 1, `w_en` = 3'b010 on `pix_valid` cycles, `ledr` = 10'b0000010100, `frame_count` = 1.
- `sw` = 3'b101 → channel 0 wins. A 10-cycle pulse on `sw[1]` → no change in `sw_db` or in the FSM.
- While ACTIVE on ch0, set `sw` = 3'b100 mid-frame → `w_en[0]` continues until the next `frame_start`, then `w_en` = 3'b100 from the following cycle. `frame_count` increments by 1.
- `sw_clr` coincident with `frame_start` in ACTIVE → IDLE next cycle, `w_en` = 0 that same cycle, `frame_count` unchanged.
- `rst` asserted mid-frame with `pix_valid` high → all outputs at reset values after one edge. 256 frames with `CNT_W` = 8 → `frame_count` wraps to 0.
- `NUM_CH` = 7 build: `sw[6]` alone → `w_en` = 7'b1000000, `ledr[9]` = 1 when ACTIVE.
